// File: rtl/fft_status_reg.sv
// Purpose: per-channel FFT job tracker (IDLE/BUSY/DONE/TMO) with cycle counter, status read port and interrupt.
// Latency: state updates 1 cycle after an event; irq 1 cycle after DONE/TMO is entered; read data 1 cycle after rd_en.
// Backpressure: none; reads are always accepted and answered on the next cycle.
module fft_status_reg #(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = 16,
    parameter int unsigned TIMEOUT     = 16'hFFFF,
    parameter bit          CLR_ON_READ = 1'b1,
    localparam int         SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] core_done,
    input  logic [NUM_CH-1:0] clr,
    input  logic [NUM_CH-1:0] irq_en,
    input  logic              rd_en,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [CNT_W+1:0]  rd_data,
    output logic              rd_valid,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done,
    output logic              irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_TMO  = 2'd3
    } ch_state_e;

    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT);

    ch_state_e        st_q  [NUM_CH];
    logic [CNT_W-1:0] cyc_q [NUM_CH];
    logic [NUM_CH-1:0] core_done_q;

    logic [NUM_CH-1:0] done_rise;
    logic [NUM_CH-1:0] rd_hit;
    logic [NUM_CH-1:0] ch_clr;
    logic [CNT_W+1:0]  rd_data_d;
    logic              irq_d;

    // Event decode: edge detect, read-select match, clear requests, read mux and irq term.
    always_comb begin
        done_rise = core_done & ~core_done_q;
        rd_hit    = '0;
        ch_clr    = clr;
        rd_data_d = '0;
        irq_d     = 1'b0;
        busy      = '0;
        done      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_hit[i] = rd_en && (rd_sel == SEL_W'(i));
            // Only finished channels are consumed by a read; IDLE/BUSY reads are side-effect free.
            if (CLR_ON_READ && rd_hit[i] && (st_q[i] == ST_DONE || st_q[i] == ST_TMO))
                ch_clr[i] = 1'b1;
            if (rd_sel == SEL_W'(i))
                rd_data_d = {st_q[i], cyc_q[i]};
            if (irq_en[i] && (st_q[i] == ST_DONE || st_q[i] == ST_TMO))
                irq_d = 1'b1;
            busy[i] = (st_q[i] == ST_BUSY);
            done[i] = (st_q[i] == ST_DONE);
        end
    end

    // Per-channel job FSM and cycle counter; clear beats start, completion beats timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_done_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]  <= ST_IDLE;
                cyc_q[i] <= '0;
            end
        end else begin
            core_done_q <= core_done;
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_clr[i]) begin
                    st_q[i] <= ST_IDLE;
                end else begin
                    case (st_q[i])
                        ST_IDLE, ST_DONE, ST_TMO: begin
                            if (start[i]) begin
                                st_q[i]  <= ST_BUSY;
                                cyc_q[i] <= '0;
                            end
                        end
                        ST_BUSY: begin
                            if (done_rise[i]) begin
                                st_q[i] <= ST_DONE;
                            end else if (cyc_q[i] == TMO_LIM) begin
                                st_q[i] <= ST_TMO;
                            end else begin
                                cyc_q[i] <= cyc_q[i] + CNT_W'(1);
                            end
                        end
                        default: st_q[i] <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    // Registered read response and interrupt; rd_data holds its last value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            irq      <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_data_d;
            irq <= irq_d;
        end
    end

endmodule

// File: tb/tb_fft_status_reg.sv
// Directed bench for fft_status_reg: instance A uses defaults, instance B uses 3 channels,
// an 8-bit counter and TIMEOUT=8 so timeouts and out-of-range selects are reachable.
module tb_fft_status_reg;

    logic       clk;
    logic       rst;
    logic [3:0] start;
    logic [3:0] core_done;
    logic [3:0] clr;
    logic [3:0] irq_en;
    logic       rd_en;
    logic [1:0] rd_sel;

    logic [17:0] a_rd_data;
    logic        a_rd_valid;
    logic [3:0]  a_busy;
    logic [3:0]  a_done;
    logic        a_irq;

    logic [9:0]  b_rd_data;
    logic        b_rd_valid;
    logic [2:0]  b_busy;
    logic [2:0]  b_done;
    logic        b_irq;

    int n_chk;
    int n_pass;

    fft_status_reg dut_a (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .core_done (core_done),
        .clr       (clr),
        .irq_en    (irq_en),
        .rd_en     (rd_en),
        .rd_sel    (rd_sel),
        .rd_data   (a_rd_data),
        .rd_valid  (a_rd_valid),
        .busy      (a_busy),
        .done      (a_done),
        .irq       (a_irq)
    );

    fft_status_reg #(
        .NUM_CH  (3),
        .CNT_W   (8),
        .TIMEOUT (8)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .start     (start[2:0]),
        .core_done (core_done[2:0]),
        .clr       (clr[2:0]),
        .irq_en    (irq_en[2:0]),
        .rd_en     (rd_en),
        .rd_sel    (rd_sel),
        .rd_data   (b_rd_data),
        .rd_valid  (b_rd_valid),
        .busy      (b_busy),
        .done      (b_done),
        .irq       (b_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Advance one clock; inputs set before the call are sampled at this edge, outputs are read 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1; start = '0; core_done = '0; clr = '0; irq_en = '0; rd_en = 1'b0; rd_sel = '0;

        // Reset state; inputs are ignored while rst is high.
        tick();
        start = 4'hF; rd_en = 1'b1; irq_en = 4'hF;
        tick();
        check("rst_busy", 32'(a_busy), 32'h0);
        check("rst_done", 32'(a_done), 32'h0);
        check("rst_irq", 32'(a_irq), 32'h0);
        check("rst_rd_valid", 32'(a_rd_valid), 32'h0);
        check("rst_rd_data", 32'(a_rd_data), 32'h0);
        rst = 1'b0; start = '0; rd_en = 1'b0; irq_en = '0;
        tick();

        // Basic run on channel 0: busy cycles 1..10, DONE at 11 with 9 cycles, irq at 12.
        irq_en = 4'b0001;
        start = 4'b0001;
        tick();
        start = '0;
        for (int k = 1; k <= 9; k++) begin
            check("run0_busy", 32'(a_busy[0]), 32'h1);
            tick();
        end
        check("run0_busy_c10", 32'(a_busy[0]), 32'h1);
        core_done = 4'b0001;
        tick();
        check("run0_done_c11", 32'(a_done[0]), 32'h1);
        check("run0_notbusy_c11", 32'(a_busy[0]), 32'h0);
        check("run0_irq_c11", 32'(a_irq), 32'h0);
        tick();
        check("run0_irq_c12", 32'(a_irq), 32'h1);
        rd_en = 1'b1; rd_sel = 2'd0;
        tick();
        rd_en = 1'b0;
        check("run0_rd_valid", 32'(a_rd_valid), 32'h1);
        check("run0_rd_data", 32'(a_rd_data), 32'h20009);
        check("run0_cleared", 32'(a_done[0]), 32'h0);
        // B channel 0 timed out at cycle 10, so the core_done rise was ignored.
        check("b_run0_rd_data", 32'(b_rd_data), 32'h308);
        tick();
        check("run0_rd_valid_low", 32'(a_rd_valid), 32'h0);
        check("run0_rd_data_hold", 32'(a_rd_data), 32'h20009);
        check("run0_irq_low", 32'(a_irq), 32'h0);
        core_done = '0;

        // Timeout on B channel 1: 9 BUSY cycles, TMO with 8, read returns {11,8} and clears.
        irq_en = 4'b0010;
        start = 4'b0010;
        tick();
        start = '0;
        for (int k = 0; k < 9; k++) begin
            check("tmo_busy", 32'(b_busy[1]), 32'h1);
            tick();
        end
        check("tmo_left_busy", 32'(b_busy[1]), 32'h0);
        check("tmo_not_done", 32'(b_done[1]), 32'h0);
        tick();
        check("tmo_irq", 32'(b_irq), 32'h1);
        rd_en = 1'b1; rd_sel = 2'd1;
        tick();
        rd_en = 1'b0;
        check("tmo_rd_valid", 32'(b_rd_valid), 32'h1);
        check("tmo_rd_data", 32'(b_rd_data), 32'h308);
        tick();
        check("tmo_irq_after_read", 32'(b_irq), 32'h0);
        // A channel 1 is still BUSY; a read of it must not disturb it.
        rd_en = 1'b1; rd_sel = 2'd1;
        tick();
        rd_en = 1'b0;
        check("busy_rd_state", 32'(a_rd_data[17:16]), 32'h1);
        tick();
        check("busy_rd_no_side_effect", 32'(a_busy[1]), 32'h1);

        // Stuck-high core_done on A channel 2 must not complete a new run.
        irq_en = '0;
        core_done = 4'b0100;
        tick();
        start = 4'b0100;
        tick();
        start = '0;
        tick(); tick(); tick();
        check("stuck_busy", 32'(a_busy[2]), 32'h1);
        check("stuck_not_done", 32'(a_done[2]), 32'h0);
        core_done = 4'b0000;
        tick();
        check("stuck_low_busy", 32'(a_busy[2]), 32'h1);
        core_done = 4'b0100;
        tick();
        check("stuck_rise_done", 32'(a_done[2]), 32'h1);
        check("stuck_rise_notbusy", 32'(a_busy[2]), 32'h0);
        rd_en = 1'b1; rd_sel = 2'd2;
        tick();
        rd_en = 1'b0;
        check("stuck_rd_data", 32'(a_rd_data), 32'h20004);
        core_done = '0;
        tick();

        // clr and start together while DONE: channel goes IDLE, start ignored.
        start = 4'b0001;
        tick();
        start = '0;
        core_done = 4'b0001;
        tick();
        check("clr_pre_done", 32'(a_done[0]), 32'h1);
        clr = 4'b0001; start = 4'b0001;
        tick();
        clr = '0; start = '0; core_done = '0;
        check("clr_start_done", 32'(a_done[0]), 32'h0);
        check("clr_start_busy", 32'(a_busy[0]), 32'h0);

        // Reset mid-BUSY on all channels.
        start = 4'hF;
        tick();
        start = '0;
        check("all_busy", 32'(a_busy), 32'hF);
        rst = 1'b1; rd_en = 1'b1; irq_en = 4'hF;
        tick();
        rst = 1'b0; rd_en = 1'b0; irq_en = '0;
        check("midrst_busy", 32'(a_busy), 32'h0);
        check("midrst_done", 32'(a_done), 32'h0);
        check("midrst_irq", 32'(a_irq), 32'h0);
        check("midrst_rd_valid", 32'(a_rd_valid), 32'h0);
        check("midrst_rd_data", 32'(a_rd_data), 32'h0);
        check("midrst_b_busy", 32'(b_busy), 32'h0);

        // Out-of-range select on B returns 0 with rd_valid, after a nonzero read.
        start = 4'b0001;
        tick();
        start = '0;
        tick(); tick();
        rd_en = 1'b1; rd_sel = 2'd0;
        tick();
        check("b_busy_rd_data", 32'(b_rd_data), 32'h102);
        rd_sel = 2'd3;
        tick();
        rd_en = 1'b0;
        check("oor_rd_valid", 32'(b_rd_valid), 32'h1);
        check("oor_rd_data", 32'(b_rd_data), 32'h0);
        check("oor_no_clear", 32'(b_busy[0]), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_status_reg.md
FFT_STATUS_REG -- requirements
Module: fft_status_reg

Parameters
REQ-001 NUM_CH, default 4, number of independent FFT core channels (1..16) SHALL be supported.
REQ-002 CNT_W, default 16, cycle-counter width SHALL be supported.
REQ-003 TIMEOUT, default 16'hFFFF, max BUSY count before timeout; TIMEOUT SHALL be ≤ 2^CNT_W-1.
REQ-004 CLR_ON_READ, default 1; when 1, a read of a DONE/TMO channel SHALL clear it.

Interface
REQ-005 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 start  in  NUM_CH  per-channel 1-cycle start pulse.
REQ-008 core_done  in  NUM_CH  per-channel done level from core, active-high.
REQ-009 clr  in  NUM_CH  per-channel clear pulse.
REQ-010 irq_en  in  NUM_CH  per-channel interrupt enable.
REQ-011 rd_en  in  1  status read strobe.
REQ-012 rd_sel  in  SEL_W  channel select; SEL_W = max(1, clog2(NUM_CH)).
REQ-013 rd_data  out  CNT_W+2  read data {state[1:0], cycles[CNT_W-1:0]}.
REQ-014 rd_valid  out  1  read data valid.
REQ-015 busy  out  NUM_CH  channel in BUSY.
REQ-016 done  out  NUM_CH  sticky done; channel in DONE.
REQ-017 irq  out  1  interrupt.

Function
REQ-018 Each channel SHALL run an FSM: IDLE=0, BUSY=1, DONE=2, TMO=3.
REQ-019 Each channel SHALL register core_done into core_done_q every cycle; done_rise = core_done & ~core_done_q.
REQ-020 clr[i], or a CLR_ON_READ read of channel i, SHALL take priority: channel i goes to IDLE next cycle from any state, and start[i] is ignored that cycle.
REQ-021 IDLE/DONE/TMO + start[i], with no clear: -> BUSY, cycles cleared to 0.
REQ-022 BUSY + done_rise: -> DONE, with cycles held; done_rise SHALL have priority over timeout.
REQ-023 BUSY, no done_rise, cycles == TIMEOUT: -> TMO, with cycles held at TIMEOUT.
REQ-024 BUSY, no done_rise, cycles < TIMEOUT: cycles += 1.
REQ-025 start[i] in BUSY SHALL be ignored.
REQ-026 done_rise outside BUSY SHALL be ignored; a core_done level stuck high from a prior run SHALL NOT complete a new run.
REQ-027 cycles SHALL never wrap, because the TIMEOUT limit bounds it.
REQ-028 busy[i] = (state==BUSY) and done[i] = (state==DONE), both decoded directly from state registers.
REQ-029 irq SHALL be registered: irq <= OR over i of (irq_en[i] & (state[i]==DONE | state[i]==TMO)); it asserts 1 cycle after the state is entered.
REQ-030 Read: rd_en at cycle N SHALL give rd_valid=1 at N+1, with rd_data showing channel rd_sel's state and cycles as of cycle N (pre-clear).
REQ-031 rd_valid SHALL be 0 whenever rd_en was 0 in the prior cycle; rd_data SHALL then hold its last value.
REQ-032 rd_sel ≥ NUM_CH SHALL return rd_data=0 with rd_valid=1 and clear no channel.
REQ-033 With CLR_ON_READ=1, a read SHALL clear only a channel in DONE/TMO; a read of IDLE/BUSY SHALL have no side effect.
REQ-034 Channels SHALL operate fully independently; simultaneous events on different channels SHALL all take effect in the same cycle.

Reset
REQ-035 rst=1 SHALL, at the next edge: set all states to IDLE and all cycles, core_done_q, rd_data, rd_valid, and irq to 0. This includes reset asserted mid-BUSY.
REQ-036 While rst=1, all inputs SHALL be ignored.

Verification
REQ-037 start[0] at cycle 0, core_done[0] rises at cycle 10 -> busy[0]=1 for cycles 1..10, done[0]=1 from cycle 11, cycles=9, irq=1 at cycle 12 with irq_en[0]=1.
REQ-038 TIMEOUT=8, start[1], core_done low -> TMO after 9 BUSY cycles, cycles=8; then rd_en with rd_sel=1 -> rd_data={2'b11,8}, and the channel is IDLE the cycle after the read.
REQ-039 core_done[2] held high, start[2] -> channel stays BUSY; core_done low then high -> DONE.
REQ-040 clr[0] and start[0] in the same cycle while in DONE -> IDLE; the start is ignored.
REQ-041 rst=1 mid-BUSY on all channels -> all outputs 0 and all states IDLE the next cycle; rd_sel=NUM_CH read -> rd_data=0, rd_valid=1.
